// File: rtl/time_setting_pkg.sv
// Shared types, constants and digit arithmetic for the time field editor.
package time_setting_pkg;

    localparam int DIGIT_W = 4;

    // Per-digit limits for a MMDDhhmmss field, leftmost digit in the MSB nibble.
    localparam logic [39:0] DEFAULT_DIGIT_MAX = 40'h19_39_29_59_59;

    typedef enum logic {
        EDIT = 1'b0,
        PEND = 1'b1
    } edit_state_t;

    // +1 against limit m. A digit already above its limit (loaded) is treated as at the limit.
    function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] m,
                                                   input logic wrap);
        logic [DIGIT_W-1:0] r;
        if (d >= m) r = wrap ? '0 : m;
        else        r = d + 1'b1;
        return r;
    endfunction

    // -1 against limit m. An out-of-range digit snaps back to the limit.
    function automatic logic [DIGIT_W-1:0] bcd_dec(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] m,
                                                   input logic wrap);
        logic [DIGIT_W-1:0] r;
        if (d == '0)    r = wrap ? m : '0;
        else if (d > m) r = m;
        else            r = d - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/time_field_editor_if.sv
// Commit handshake between the editor (master) and the timekeeping core (slave).
interface time_field_editor_if
    import time_setting_pkg::*;
#(
    parameter int NUM_DIGITS = 10
);
    logic [DIGIT_W*NUM_DIGITS-1:0] time_value;
    logic                          time_valid;
    logic                          time_ready;
    logic                          set_time_mode;

    modport master (
        output time_value,
        output time_valid,
        output set_time_mode,
        input  time_ready
    );

    modport slave (
        input  time_value,
        input  time_valid,
        input  set_time_mode,
        output time_ready
    );
endinterface

// File: rtl/time_field_editor_btn_event.sv
// Button rise detector. With TIME_EDIT_AUTOREPEAT_EN defined, a held button (while
// rep_en_i is high) also emits repeat events: first after REPEAT_DLY cycles, then every
// REPEAT_PER cycles. The repeat timer is a down-counter cleared on release or when
// rep_en_i drops.
module btn_event #(
    parameter logic [15:0] REPEAT_DLY = 16'd5000,
    parameter logic [15:0] REPEAT_PER = 16'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic rep_en_i,
    output logic evt_o
);
    logic btn_q, btn_d;
    logic rise;

    assign btn_d = btn_i;
    assign rise  = btn_i & ~btn_q;

    // Previous button level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn_d;
    end

`ifdef TIME_EDIT_AUTOREPEAT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        rep;

    // Hold timer: load delay on rise, fire and reload period at terminal count.
    always_comb begin
        cnt_d = '0;
        rep   = 1'b0;
        if (rise && rep_en_i) begin
            cnt_d = REPEAT_DLY;
        end else if (btn_i && rep_en_i && cnt_q != '0) begin
            if (cnt_q == 16'd1) begin
                rep   = 1'b1;
                cnt_d = REPEAT_PER;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign evt_o = rise | rep;
`else
    logic unused_cfg;
    assign unused_cfg = ^{rep_en_i, REPEAT_DLY, REPEAT_PER};
    assign evt_o      = rise;
`endif

endmodule

// File: rtl/time_field_editor.sv
// Digit-field editor for clock/calendar setting with a valid/ready commit port.
// Optional feature macro: TIME_EDIT_AUTOREPEAT_EN (auto-repeat on held inc/dec).
//
//  state | meaning
//  EDIT  | buttons edit digits/cursor; commit captures digits and raises time_valid
//  PEND  | commit offered; edits ignored, time_value frozen until valid&ready
module time_field_editor
    import time_setting_pkg::*;
#(
    parameter int                            NUM_DIGITS = 10,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DIGIT_MAX  = DEFAULT_DIGIT_MAX,
    parameter int                            WRAP       = 1,
    parameter logic [15:0]                   REPEAT_DLY = 16'd5000,
    parameter logic [15:0]                   REPEAT_PER = 16'd1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            edit_en,
    input  logic                            btn_inc,
    input  logic                            btn_dec,
    input  logic                            btn_next,
    input  logic                            btn_prev,
    input  logic                            btn_commit,
    input  logic                            load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]   load_value,
    output logic [DIGIT_W*NUM_DIGITS-1:0]   digits,
    output logic [$clog2(NUM_DIGITS)-1:0]   cursor,
    time_field_editor_if.master             tif
);
    localparam int                 CUR_W = $clog2(NUM_DIGITS);
    localparam logic [CUR_W-1:0]   LAST  = CUR_W'(NUM_DIGITS - 1);
    localparam int                 VAL_W = DIGIT_W * NUM_DIGITS;

    edit_state_t       state_q, state_d;
    logic [VAL_W-1:0]  digits_q, digits_d;
    logic [CUR_W-1:0]  cursor_q, cursor_d;
    logic [VAL_W-1:0]  time_value_q, time_value_d;
    logic              time_valid_q, time_valid_d;
    logic              stm_q, stm_d;

    logic inc_ev, dec_ev, next_ev, prev_ev, commit_ev;
    logic rep_en;
    logic do_commit, do_edit, hs;
    logic [DIGIT_W-1:0] cur_digit, cur_max;

    assign rep_en = edit_en & (state_q == EDIT);

    btn_event #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_inc (
        .clk(clk), .rst(rst), .btn_i(btn_inc),    .rep_en_i(rep_en), .evt_o(inc_ev));
    btn_event #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dec (
        .clk(clk), .rst(rst), .btn_i(btn_dec),    .rep_en_i(rep_en), .evt_o(dec_ev));
    btn_event #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_next (
        .clk(clk), .rst(rst), .btn_i(btn_next),   .rep_en_i(1'b0),   .evt_o(next_ev));
    btn_event #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_prev (
        .clk(clk), .rst(rst), .btn_i(btn_prev),   .rep_en_i(1'b0),   .evt_o(prev_ev));
    btn_event #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_commit (
        .clk(clk), .rst(rst), .btn_i(btn_commit), .rep_en_i(1'b0),   .evt_o(commit_ev));

    // Load outranks commit, which outranks any digit or cursor edit.
    assign do_commit = (state_q == EDIT) & edit_en & commit_ev & ~load;
    assign do_edit   = (state_q == EDIT) & edit_en & ~commit_ev & ~load;
    assign hs        = (state_q == PEND) & time_valid_q & tif.time_ready;

    assign cur_digit = digits_q[cursor_q*DIGIT_W +: DIGIT_W];
    assign cur_max   = DIGIT_MAX[cursor_q*DIGIT_W +: DIGIT_W];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EDIT;
        else     state_q <= state_d;
    end

    // FSM next state: commit offers the value, handshake returns to editing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EDIT: if (do_commit) state_d = PEND;
            PEND: if (hs)        state_d = EDIT;
        endcase
    end

    // Datapath: digit/cursor edits, commit capture and handshake outputs.
    always_comb begin
        digits_d     = digits_q;
        cursor_d     = cursor_q;
        time_value_d = time_value_q;
        time_valid_d = time_valid_q;
        stm_d        = 1'b0;
        if (load) begin
            digits_d = load_value;
        end else if (do_edit) begin
            if (inc_ev && !dec_ev)
                digits_d[cursor_q*DIGIT_W +: DIGIT_W] = bcd_inc(cur_digit, cur_max, WRAP != 0);
            else if (dec_ev && !inc_ev)
                digits_d[cursor_q*DIGIT_W +: DIGIT_W] = bcd_dec(cur_digit, cur_max, WRAP != 0);
            if (next_ev && !prev_ev)
                cursor_d = (cursor_q == '0) ? LAST : cursor_q - 1'b1;
            else if (prev_ev && !next_ev)
                cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 1'b1;
        end
        if (do_commit) begin
            time_value_d = digits_q;
            time_valid_d = 1'b1;
        end
        if (hs) begin
            time_valid_d = 1'b0;
            stm_d        = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q     <= '0;
            cursor_q     <= LAST;
            time_value_q <= '0;
            time_valid_q <= 1'b0;
            stm_q        <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            cursor_q     <= cursor_d;
            time_value_q <= time_value_d;
            time_valid_q <= time_valid_d;
            stm_q        <= stm_d;
        end
    end

    assign digits            = digits_q;
    assign cursor            = cursor_q;
    assign tif.time_value    = time_value_q;
    assign tif.time_valid    = time_valid_q;
    assign tif.set_time_mode = stm_q;

endmodule

// File: tb/tb_time_field_editor.sv
// Directed bench for time_field_editor; committed values are checked by a handshake monitor.
module tb_time_field_editor;
    localparam int ND = 10;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         edit_en = 1'b0;
    logic         btn_inc = 1'b0, btn_dec = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, btn_commit = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] digits;
    logic [3:0]   cursor;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic hs_prev = 1'b0;

    time_field_editor_if #(.NUM_DIGITS(ND)) tif ();

    time_field_editor #(
        .NUM_DIGITS(ND), .DIGIT_MAX(40'h19_39_29_59_59), .WRAP(1),
        .REPEAT_DLY(16'd8), .REPEAT_PER(16'd4)
    ) dut (
        .clk(clk), .rst(rst), .edit_en(edit_en),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_commit(btn_commit), .load(load), .load_value(load_value),
        .digits(digits), .cursor(cursor), .tif(tif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // b = {inc, dec, next, prev, commit}; one-cycle press then release.
    task automatic press(input logic [4:0] b);
        {btn_inc, btn_dec, btn_next, btn_prev, btn_commit} = b;
        tick(1);
        {btn_inc, btn_dec, btn_next, btn_prev, btn_commit} = 5'b0;
        tick(1);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load_value = v;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(1);
    endtask

    // Monitor: pops expected commit value on each handshake, checks the set_time_mode pulse.
    always begin
        @(negedge clk);
        #1;
        total++;
        if (tif.set_time_mode !== hs_prev) begin
            bad++;
            $display("FAIL set_time_mode: got %b want %b", tif.set_time_mode, hs_prev);
        end
        hs_prev = !rst && tif.time_valid && tif.time_ready;
        if (hs_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL handshake_unexpected: got %h want no handshake", tif.time_value);
            end else begin
                check("time_value_hs", tif.time_value, exp_q.pop_front());
            end
        end
    end

    initial begin
        tif.time_ready = 1'b0;
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("rst_digits", digits, '0);
        check("rst_cursor", W'(cursor), W'(9));
        check("rst_valid", W'(tif.time_valid), '0);
        check("rst_value", tif.time_value, '0);
        check("rst_stm", W'(tif.set_time_mode), '0);

        edit_en = 1'b1;
        press(5'b10000);
        check("inc_d9_1", digits, 40'h1000000000);
        press(5'b10000);
        check("inc_d9_wrap", digits, 40'h0000000000);

        repeat (4) press(5'b00100);
        check("cursor_to_5", W'(cursor), W'(5));
        press(5'b01000);
        check("dec_wrap_d5", digits, 40'h0000200000);
        press(5'b01000);
        check("dec_d5", digits, 40'h0000100000);

        edit_en = 1'b0;
        press(5'b10000);
        check("edit_disabled", digits, 40'h0000100000);
        edit_en = 1'b1;

        press(5'b11000);
        check("inc_dec_same", digits, 40'h0000100000);
        press(5'b00110);
        check("next_prev_same", W'(cursor), W'(5));
        press(5'b10100);
        check("inc_next_digit", digits, 40'h0000200000);
        check("inc_next_cursor", W'(cursor), W'(4));

        repeat (5) press(5'b00010);
        check("prev_to_9", W'(cursor), W'(9));
        press(5'b00010);
        check("prev_wrap", W'(cursor), W'(0));
        press(5'b00100);
        check("next_wrap", W'(cursor), W'(9));

        do_load(40'h1231235958);
        check("load", digits, 40'h1231235958);

        exp_q.push_back(40'h1231235958);
        press(5'b00001);
        check("commit_valid", W'(tif.time_valid), W'(1));
        check("commit_value", tif.time_value, 40'h1231235958);
        press(5'b10000);
        tick(8);
        check("pend_inc_ignored", digits, 40'h1231235958);
        check("pend_valid_held", W'(tif.time_valid), W'(1));
        do_load(40'h0102030405);
        check("pend_load_digits", digits, 40'h0102030405);
        check("pend_value_frozen", tif.time_value, 40'h1231235958);
        tif.time_ready = 1'b1;
        tick(1);
        tif.time_ready = 1'b0;
        tick(1);
        check("valid_dropped", W'(tif.time_valid), '0);
        press(5'b10000);
        check("edit_resumed", digits, 40'h1102030405);

        do_load(40'h9000000000);
        press(5'b10000);
        check("oor_inc", digits, 40'h0000000000);
        do_load(40'h9000000000);
        press(5'b01000);
        check("oor_dec", digits, 40'h1000000000);

        exp_q.push_back(40'h1000000000);
        press(5'b10001);
        check("commit_beats_inc", digits, 40'h1000000000);
        check("commit_inc_valid", W'(tif.time_valid), W'(1));
        tif.time_ready = 1'b1;
        tick(1);
        tif.time_ready = 1'b0;
        tick(1);

        press(5'b00001);
        check("pend_before_rst", W'(tif.time_valid), W'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_pend_valid", W'(tif.time_valid), '0);
        check("rst_pend_digits", digits, '0);
        check("rst_pend_cursor", W'(cursor), W'(9));
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        press(5'b00010);
        check("cursor_d0", W'(cursor), W'(0));
        btn_inc = 1'b1;
        tick(21);
        btn_inc = 1'b0;
        tick(2);
`ifdef TIME_EDIT_AUTOREPEAT_EN
        check("autorepeat_count", digits, 40'h0000000005);
`else
        check("held_single_event", digits, 40'h0000000001);
`endif
        tick(2);
        check("scoreboard_drained", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
